// File: rtl/seq_mult_param.sv
// ============================================================================
// seq_mult_param
// ----------------------------------------------------------------------------
// Purpose:
//   Parametrised sequential shift-add multiplier. One multiplier bit is
//   retired per clock, LSB first, so an operation takes WIDTH cycles in RUN.
//   A run-time mode flag selects plain unsigned shift-add or radix-2 Booth
//   recoding for two's-complement operands. A start/busy/done handshake
//   drives the unit, and the finished product sits in a held result
//   register that only changes when an operation completes.
//
// Parameters:
//   WIDTH        operand width in bits (2..32); product is 2*WIDTH bits
//   CNT_W        width of the bit counter; derived from WIDTH, leave alone
//
// Ports:
//   system_clk   in   1          rising-edge clock for all state
//   rst          in   1          synchronous active-high reset
//   load         in   1          start request, honoured only in IDLE/DONE
//   signed_mode  in   1          0 = unsigned, 1 = two's complement
//   a            in   WIDTH      multiplicand, captured with load
//   b            in   WIDTH      multiplier, captured with load
//   X            out  WIDTH      latched multiplicand
//   Y            out  WIDTH      latched multiplier
//   busy         out  1          high while the multiply is running
//   done         out  1          one-cycle pulse when product is updated
//   product      out  2*WIDTH    held result of the last finished operation
// ============================================================================
module seq_mult_param #(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     X,
  output logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Three-state controller: waiting, shifting through the multiplier bits,
  // and the single completion cycle in which done is presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic                 r_mode;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_start;
  logic                 w_lastBit;
  logic [WIDTH:0]       w_yExt;
  logic [1:0]           w_pair;
  logic [2*WIDTH-1:0]   w_xExt;
  logic [2*WIDTH-1:0]   w_term;
  logic [2*WIDTH-1:0]   w_accNext;

  // The latched operands and the result register are the visible outputs;
  // nothing combinational sits between them and the ports.
  assign X       = r_x;
  assign Y       = r_y;
  assign product = r_product;

  // The counter points at the multiplier bit being retired this cycle.
  // Reaching WIDTH-1 means this cycle folds in the final term.
  assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

  // Appending a zero below the multiplier supplies the implicit Y[-1] = 0
  // that Booth recoding needs for the first bit. Shifting this vector right
  // by the counter leaves the pair {Y[i], Y[i-1]} in the two low bits, which
  // serves both modes: unsigned only looks at the upper bit of the pair.
  assign w_yExt = {r_y, 1'b0};
  assign w_pair = 2'(w_yExt >> r_cnt);

  // The multiplicand is widened to the full product width before shifting.
  // Signed mode sign-extends so that subtracting or adding the shifted term
  // is correct modulo 2^(2*WIDTH); unsigned mode zero-extends.
  assign w_xExt = r_mode ? {{WIDTH{r_x[WIDTH-1]}}, r_x}
                         : {{WIDTH{1'b0}}, r_x};
  assign w_term = w_xExt << r_cnt;

  // Next accumulator value for the current bit. In signed mode a 10 pair
  // marks the start of a run of ones (subtract) and a 01 pair marks its end
  // (add); 00 and 11 leave the accumulator alone. This is what makes the
  // most negative operand times itself come out exact, since the top bit of
  // the multiplier contributes with negative weight.
  always_comb begin
    w_accNext = r_acc;
    if (r_mode) begin
      case (w_pair)
        2'b10:   w_accNext = r_acc - w_term;
        2'b01:   w_accNext = r_acc + w_term;
        default: w_accNext = r_acc;
      endcase
    end else if (w_pair[1]) begin
      w_accNext = r_acc + w_term;
    end
  end

  // State register. Reset forces IDLE from anywhere, including mid-RUN,
  // which abandons whatever partial result was being built.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. A load in DONE goes straight back to
  // RUN so back-to-back operations have no idle gap; done still shows for
  // that DONE cycle. Loads arriving during RUN are simply not looked at.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_start     = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (load) begin
          w_start     = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. Operands and mode are captured only on a start, so
  // they stay frozen for the whole computation regardless of what a, b and
  // signed_mode do. The result register is written only on the last RUN
  // cycle, which keeps the previous product visible while a new one is
  // being computed.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_mode    <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_start) begin
      r_x    <= a;
      r_y    <= b;
      r_mode <= signed_mode;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_accNext;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_lastBit) begin
        r_product <= w_accNext;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// ============================================================================
// tb_seq_mult_param
// ----------------------------------------------------------------------------
// Drives a WIDTH=6 and a WIDTH=8 instance of seq_mult_param. Every accepted
// operation pushes its expected product and operands into a per-instance
// queue; a monitor pops and compares whenever the instance raises done.
// Expected products come from ordinary integer multiplication on the
// operands interpreted as signed or unsigned values.
// ============================================================================
module tb_seq_mult_param;

  typedef struct {
    logic [63:0] p;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  logic        clk;

  logic        rst6, load6, mode6;
  logic [5:0]  a6, b6, x6, y6;
  logic [11:0] p6;
  logic        busy6, done6;

  logic        rst8, load8, mode8;
  logic [7:0]  a8, b8, x8, y8;
  logic [15:0] p8;
  logic        busy8, done8;

  int nChecks;
  int nPass;
  int runLen6;
  int runLen8;

  exp_t q6[$];
  exp_t q8[$];

  seq_mult_param #(.WIDTH(6)) dut6 (
    .system_clk  (clk),
    .rst         (rst6),
    .load        (load6),
    .signed_mode (mode6),
    .a           (a6),
    .b           (b6),
    .X           (x6),
    .Y           (y6),
    .busy        (busy6),
    .done        (done6),
    .product     (p6)
  );

  seq_mult_param #(.WIDTH(8)) dut8 (
    .system_clk  (clk),
    .rst         (rst8),
    .load        (load8),
    .signed_mode (mode8),
    .a           (a8),
    .b           (b8),
    .X           (x8),
    .Y           (y8),
    .busy        (busy8),
    .done        (done8),
    .product     (p8)
  );

  // Free-running clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence below.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wOf(int u);
    return (u == 0) ? 6 : 8;
  endfunction

  function automatic logic [31:0] mask32(int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Reference: plain integer multiply of the operands taken as signed or
  // unsigned values, reduced to the 2*w-bit product width.
  function automatic logic [63:0] refProd(int w, logic [31:0] a, logic [31:0] b, bit s);
    longint sa;
    longint sb;
    longint full;
    sa = longint'(a & mask32(w));
    sb = longint'(b & mask32(w));
    if (s) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    full = sa * sb;
    return 64'(full) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [63:0] getProd(int u);
    return (u == 0) ? 64'(p6) : 64'(p8);
  endfunction

  function automatic logic [63:0] getX(int u);
    return (u == 0) ? 64'(x6) : 64'(x8);
  endfunction

  function automatic logic [63:0] getY(int u);
    return (u == 0) ? 64'(y6) : 64'(y8);
  endfunction

  function automatic logic [63:0] getBusy(int u);
    return (u == 0) ? 64'(busy6) : 64'(busy8);
  endfunction

  function automatic logic [63:0] getDone(int u);
    return (u == 0) ? 64'(done6) : 64'(done8);
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] expv);
    nChecks++;
    if (act === expv) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic failNote(string name);
    nChecks++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic setInputs(int u, bit ld, logic [31:0] a, logic [31:0] b, bit s);
    if (u == 0) begin
      load6 = ld;
      a6    = a[5:0];
      b6    = b[5:0];
      mode6 = s;
    end else begin
      load8 = ld;
      a8    = a[7:0];
      b8    = b[7:0];
      mode8 = s;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a load for one clock edge. When track is set the operation is
  // expected to complete and its result is queued for the monitor. After
  // the edge the operand inputs are scrambled to show they are not re-read.
  task automatic applyStimulus(int u, logic [31:0] a, logic [31:0] b, bit s, bit track);
    exp_t e;
    int w;
    w   = wOf(u);
    e.p = refProd(w, a, b, s);
    e.x = a & mask32(w);
    e.y = b & mask32(w);
    if (track) begin
      if (u == 0) q6.push_back(e);
      else        q8.push_back(e);
    end
    setInputs(u, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    setInputs(u, 1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  // Count falling edges until done shows; returns at the falling edge
  // inside the done cycle.
  task automatic waitDone(int u, output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (getDone(u) == 64'd1) break;
    end
    if (getDone(u) != 64'd1) begin
      failNote($sformatf("u%0d done timeout after %0d cycles", u, n));
    end
  endtask

  task automatic runOp(int u, logic [31:0] a, logic [31:0] b, bit s);
    int n;
    applyStimulus(u, a, b, s, 1'b1);
    waitDone(u, n);
    checkOutput($sformatf("u%0d latency", u), 64'(n), 64'(wOf(u) + 1));
  endtask

  task automatic checkReset(int u);
    checkOutput($sformatf("u%0d reset product", u), getProd(u), 64'd0);
    checkOutput($sformatf("u%0d reset X", u), getX(u), 64'd0);
    checkOutput($sformatf("u%0d reset Y", u), getY(u), 64'd0);
    checkOutput($sformatf("u%0d reset busy", u), getBusy(u), 64'd0);
    checkOutput($sformatf("u%0d reset done", u), getDone(u), 64'd0);
  endtask

  task automatic randomOps(int u, int count);
    for (int i = 0; i < count; i++) begin
      runOp(u, $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(1 + $urandom_range(0, 2));
    end
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare
  // product and latched operands; also confirm busy was high for exactly
  // WIDTH cycles right before the pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done6) begin
      if (q6.size() == 0) begin
        failNote("u0 unexpected done");
      end else begin
        e = q6.pop_front();
        checkOutput("u0 product", 64'(p6), e.p);
        checkOutput("u0 X", 64'(x6), 64'(e.x));
        checkOutput("u0 Y", 64'(y6), 64'(e.y));
        checkOutput("u0 busy cycles", 64'(runLen6), 64'd6);
      end
      runLen6 = 0;
    end else if (busy6) begin
      runLen6++;
    end else begin
      runLen6 = 0;
    end

    if (done8) begin
      if (q8.size() == 0) begin
        failNote("u1 unexpected done");
      end else begin
        e = q8.pop_front();
        checkOutput("u1 product", 64'(p8), e.p);
        checkOutput("u1 X", 64'(x8), 64'(e.x));
        checkOutput("u1 Y", 64'(y8), 64'(e.y));
        checkOutput("u1 busy cycles", 64'(runLen8), 64'd8);
      end
      runLen8 = 0;
    end else if (busy8) begin
      runLen8++;
    end else begin
      runLen8 = 0;
    end
  end

  // Directed sequence followed by randomized operations on both widths.
  initial begin
    int n;
    int doneSeen;
    nChecks = 0;
    nPass   = 0;
    runLen6 = 0;
    runLen8 = 0;
    rst6 = 1'b1;
    rst8 = 1'b1;
    setInputs(0, 1'b0, 32'd0, 32'd0, 1'b0);
    setInputs(1, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(2);
    rst6 = 1'b0;
    rst8 = 1'b0;
    @(negedge clk);
    checkReset(0);
    checkReset(1);

    $display("[TB] WIDTH=6 unsigned and hold");
    runOp(0, 32'd13, 32'd20, 1'b0);
    checkOutput("u0 13*20", getProd(0), 64'h104);
    idle(3);
    @(negedge clk);
    checkOutput("u0 hold product", getProd(0), 64'd260);
    checkOutput("u0 hold done", getDone(0), 64'd0);
    checkOutput("u0 hold busy", getBusy(0), 64'd0);

    $display("[TB] WIDTH=6 signed corners");
    runOp(0, 32'd13, 32'h2C, 1'b1);
    checkOutput("u0 13*-20", getProd(0), 64'hEFC);
    idle(1);
    runOp(0, 32'h20, 32'h20, 1'b1);
    checkOutput("u0 -32*-32", getProd(0), 64'd1024);
    idle(1);
    runOp(0, 32'h20, 32'd31, 1'b1);
    checkOutput("u0 -32*31", getProd(0), 64'hC20);
    idle(1);
    runOp(0, 32'd63, 32'd63, 1'b0);
    checkOutput("u0 63*63", getProd(0), 64'hF81);
    idle(1);
    runOp(0, 32'd0, 32'd45, 1'b0);
    checkOutput("u0 0*45", getProd(0), 64'd0);

    $display("[TB] WIDTH=6 load during run is ignored");
    idle(1);
    applyStimulus(0, 32'd12, 32'd24, 1'b0, 1'b1);
    idle(2);
    setInputs(0, 1'b1, 32'd5, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    setInputs(0, 1'b0, 32'd5, 32'd5, 1'b0);
    waitDone(0, n);
    checkOutput("u0 12*24 with stray load", getProd(0), 64'd288);

    $display("[TB] WIDTH=6 reset mid-run");
    idle(1);
    applyStimulus(0, 32'd12, 32'd24, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    checkOutput("u0 product held during run", getProd(0), 64'd288);
    checkOutput("u0 busy during run", getBusy(0), 64'd1);
    rst6 = 1'b1;
    @(posedge clk);
    #1;
    rst6 = 1'b0;
    @(negedge clk);
    checkOutput("u0 abort product", getProd(0), 64'd0);
    checkOutput("u0 abort X", getX(0), 64'd0);
    checkOutput("u0 abort busy", getBusy(0), 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done6) doneSeen++;
      @(negedge clk);
    end
    checkOutput("u0 abort no done", 64'(doneSeen), 64'd0);

    $display("[TB] WIDTH=6 back-to-back");
    #1;
    runOp(0, 32'd3, 32'd4, 1'b0);
    applyStimulus(0, 32'd7, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("u0 b2b busy next cycle", getBusy(0), 64'd1);
    checkOutput("u0 b2b done single", getDone(0), 64'd0);
    waitDone(0, n);
    checkOutput("u0 b2b latency", 64'(n), 64'd6);
    checkOutput("u0 7*9", getProd(0), 64'd63);
    idle(1);

    $display("[TB] WIDTH=6 random");
    randomOps(0, 30);
    idle(2);

    $display("[TB] WIDTH=8 corners");
    runOp(1, 32'd255, 32'd255, 1'b0);
    checkOutput("u1 255*255", getProd(1), 64'd65025);
    idle(1);
    runOp(1, 32'h80, 32'h80, 1'b1);
    checkOutput("u1 -128*-128", getProd(1), 64'd16384);
    idle(1);
    runOp(1, 32'h80, 32'd127, 1'b1);
    checkOutput("u1 -128*127", getProd(1), 64'hC080);
    idle(1);

    $display("[TB] WIDTH=8 random");
    randomOps(1, 30);
    idle(4);

    checkOutput("u0 queue drained", 64'(q6.size()), 64'd0);
    checkOutput("u1 queue drained", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
